muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage, alongside alu.

---
 rtl/muldiv_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit for the execute stage.
//            Multiplies with a radix-2 shift-add into a 2*WIDTH accumulator.
//            Divides with radix-2 restoring subtract-shift. One step per
//            clock. The pipeline is stalled through o_busy_EX while an
//            operation is in flight. The result is held until the next
//            operation completes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        operand/result width (even, >= 8), default 32
// Ports
//   clk          in   1      core clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   i_start_EX   in   1      launch op; sampled only in IDLE or DONE
//   i_op_EX      in   3      funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   i_rd1_EX     in   WIDTH  rs1 operand (dividend / multiplicand)
//   i_rd2_EX     in   WIDTH  rs2 operand (divisor / multiplier)
//   i_flush_EX   in   1      abort in-flight op; wins over a same-cycle start
//   o_busy_EX    out  1      high while an op is being calculated
//   o_valid_EX   out  1      one-cycle pulse, o_result_EX is valid
//   o_result_EX  out  WIDTH  result register
// Configuration
//   MULDIV_EARLY_OUT_EN  when defined, these starts go directly to DONE:
//                        divide by zero, signed divide overflow, and a
//                        multiply with a zero operand. For these starts,
//                        o_valid_EX rises one cycle after the start and
//                        o_busy_EX stays low.
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start_EX,
  input  logic [2:0]       i_op_EX,
  input  logic [WIDTH-1:0] i_rd1_EX,
  input  logic [WIDTH-1:0] i_rd2_EX,
  input  logic             i_flush_EX,
  output logic             o_busy_EX,
  output logic             o_valid_EX,
  output logic [WIDTH-1:0] o_result_EX
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide  : {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand magnitude (mul) or divisor magnitude (div).
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2:0]           op_q, op_d;
  logic                 negres_q, negres_d;  // negate product / quotient
  logic                 negrem_q, negrem_d;  // negate remainder
  logic                 div0_q, div0_d;      // divisor was zero
  logic [WIDTH-1:0]     result_q, result_d;

  // --------------------------------------------------------------------------
  // Operand decode at launch
  // --------------------------------------------------------------------------
  logic             w_in_div;
  logic             w_in_s1, w_in_s2;
  logic             w_in_sa, w_in_sb;
  logic [WIDTH-1:0] w_in_mag1, w_in_mag2;

  always_comb begin
    w_in_div  = i_op_EX[2];
    // rs1 is signed for MULH, MULHSU, DIV and REM. rs2 is signed for
    // MULH, DIV and REM.
    w_in_s1   = (i_op_EX == 3'd1) || (i_op_EX == 3'd2) ||
                (i_op_EX == 3'd4) || (i_op_EX == 3'd6);
    w_in_s2   = (i_op_EX == 3'd1) || (i_op_EX == 3'd4) || (i_op_EX == 3'd6);
    w_in_sa   = w_in_s1 & i_rd1_EX[WIDTH-1];
    w_in_sb   = w_in_s2 & i_rd2_EX[WIDTH-1];
    // The magnitude of the most negative value wraps to itself. That value
    // is still correct when it is read as unsigned.
    w_in_mag1 = w_in_sa ? -i_rd1_EX : i_rd1_EX;
    w_in_mag2 = w_in_sb ? -i_rd2_EX : i_rd2_EX;
  end

  // --------------------------------------------------------------------------
  // Early-out detection (only with MULDIV_EARLY_OUT_EN)
  // --------------------------------------------------------------------------
  logic             w_early;
  logic [WIDTH-1:0] w_early_res;

  always_comb begin
    w_early     = 1'b0;
    w_early_res = '0;
`ifdef MULDIV_EARLY_OUT_EN
    if (w_in_div) begin
      if (i_rd2_EX == '0) begin
        w_early     = 1'b1;
        w_early_res = i_op_EX[1] ? i_rd1_EX : ALL_ONES;
      end else if (!i_op_EX[0] && (i_rd1_EX == MIN_NEG) &&
                   (i_rd2_EX == ALL_ONES)) begin
        w_early     = 1'b1;
        w_early_res = i_op_EX[1] ? '0 : MIN_NEG;
      end
    end else if ((i_rd1_EX == '0) || (i_rd2_EX == '0)) begin
      w_early     = 1'b1;
      w_early_res = '0;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // One radix-2 iteration
  // --------------------------------------------------------------------------
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH:0]       w_div_diff;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_step;

  always_comb begin
    // Shift-add: add the multiplicand into the high half when the current
    // multiplier LSB is set. Then shift the carry, sum and low half right by
    // one bit.
    w_mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    w_mul_next  = {w_mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // try to subtract. The remainder stays below the divisor, so WIDTH+1
    // bits are enough for the trial value.
    w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, opb_q};
    if (w_div_diff[WIDTH])
      w_div_next = {w_div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      w_div_next = {w_div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    w_step = op_q[2] ? w_div_next : w_mul_next;
  end

  // --------------------------------------------------------------------------
  // Sign correction and result select, taken from the final iteration
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_final;

  always_comb begin
    w_prod = negres_q ? -w_step : w_step;
    w_quo  = w_step[WIDTH-1:0];
    w_rem  = w_step[2*WIDTH-1:WIDTH];
    if (op_q[2]) begin
      if (op_q[1])
        // A zero divisor leaves |rs1| in the remainder. Applying the rs1
        // sign to it returns rs1, which is the required value.
        w_final = negrem_q ? -w_rem : w_rem;
      else
        w_final = div0_q ? ALL_ONES : (negres_q ? -w_quo : w_quo);
    end else begin
      w_final = (op_q[1:0] == 2'b00) ? w_prod[WIDTH-1:0]
                                     : w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and datapath loads
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    negres_d = negres_q;
    negrem_d = negrem_q;
    div0_d   = div0_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start_EX && !i_flush_EX) begin
          if (w_early) begin
            state_d  = S_DONE;
            result_d = w_early_res;
          end else begin
            state_d  = S_CALC;
            cnt_d    = '0;
            op_d     = i_op_EX;
            negres_d = w_in_sa ^ w_in_sb;
            negrem_d = w_in_sa;
            div0_d   = (i_rd2_EX == '0);
            if (w_in_div) begin
              acc_d = {{WIDTH{1'b0}}, w_in_mag1};
              opb_d = w_in_mag2;
            end else begin
              acc_d = {{WIDTH{1'b0}}, w_in_mag2};
              opb_d = w_in_mag1;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (i_flush_EX) begin
          state_d = S_IDLE;
        end else begin
          acc_d = w_step;
          if (cnt_q == CNT_LAST) begin
            state_d  = S_DONE;
            result_d = w_final;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      negres_q <= 1'b0;
      negrem_q <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      negres_q <= negres_d;
      negrem_q <= negrem_d;
      div0_q   <= div0_d;
      result_q <= result_d;
    end
  end

  assign o_busy_EX   = (state_q == S_CALC);
  assign o_valid_EX  = (state_q == S_DONE);
  assign o_result_EX = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit (WIDTH = 32). The stimulus
//            pushes the expected result and completion cycle into a queue.
//            A monitor pops an entry and compares it on every valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic         flush  = 1'b0;
  logic [2:0]   op     = 3'd0;
  logic [W-1:0] rd1    = '0;
  logic [W-1:0] rd2    = '0;
  wire          busy;
  wire          valid;
  wire  [W-1:0] result;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start_EX  (start),
    .i_op_EX     (op),
    .i_rd1_EX    (rd1),
    .i_rd2_EX    (rd2),
    .i_flush_EX  (flush),
    .o_busy_EX   (busy),
    .o_valid_EX  (valid),
    .o_result_EX (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   valid_cnt = 0;

  // Reference model: RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_model(input logic [2:0] f,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [63:0] pa, pb, p;
    int          sa, sbv;
    if (!f[2]) begin
      pa = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
      pb = (f == 3'd1)              ? {{32{b[31]}}, b} : {32'b0, b};
      p  = pa * pb;
      return (f == 3'd0) ? p[31:0] : p[63:32];
    end
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f[1] ? 32'h0 : 32'h8000_0000;
    sa  = a;
    sbv = b;
    case (f)
      3'd4:    return sa / sbv;
      3'd5:    return a / b;
      3'd6:    return sa % sbv;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_early(input logic [2:0] f,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (f[2])
      return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
`else
    return (f == 3'd7) && (a != a);
`endif
  endfunction

  function automatic int latency(input logic [2:0] f,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    return is_early(f, a, b) ? 1 : W + 1;
  endfunction

  // Monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      exp_t e;
      valid_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid cyc=%0d result=%h required=no pulse",
                 cyc, result);
      end else begin
        e = sb.pop_front();
        checks++;
        if (result !== e.res) begin
          errors++;
          $display("FAIL result cyc=%0d got=%h required=%h", cyc, result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency got_cycle=%0d required_cycle=%0d", cyc, e.cyc);
        end
      end
    end
  end

  // Called at #1 after a rising edge; the start is sampled at the next edge.
  task automatic launch(input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit push);
    start = 1'b1;
    op    = f;
    rd1   = a;
    rd2   = b;
    if (push) sb.push_back('{res: ref_model(f, a, b), cyc: cyc + latency(f, a, b)});
    @(posedge clk);
    #1;
    start = 1'b0;
    rd1   = $urandom;
    rd2   = $urandom;
    op    = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [W-1:0] a,
                     input logic [W-1:0] b);
    launch(f, a, b, 1'b1);
    drain();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int           c0, bcnt, n, vc;
    logic [W-1:0] saved;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy",   {31'b0, busy},  32'h0);
    check("reset_valid",  {31'b0, valid}, 32'h0);
    check("reset_result", result,         32'h0);
    @(posedge clk);
    #1;

    // MUL 7 * -3, latency and busy window
    launch(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    bcnt = 0;
    n    = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      if (busy) bcnt++;
      n++;
    end
    drain();
    check("busy_cycles", 32'(bcnt), is_early(3'd0, 32'd7, 32'hFFFF_FFFD) ? 32'd0 : 32'd32);

    // Multiply signedness
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd1, 32'h8000_0000, 32'h8000_0000);
    run(3'd2, 32'hFFFF_FFFF, 32'd2);

    // Division
    run(3'd4, 32'hFFFF_FFF9, 32'd2);
    run(3'd6, 32'hFFFF_FFF9, 32'd2);
    run(3'd5, 32'd100, 32'd7);
    run(3'd7, 32'd100, 32'd7);

    // Special cases
    run(3'd4, 32'd5, 32'd0);
    run(3'd6, 32'd5, 32'd0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd0, 32'd0, 32'h1234_5678);

    // Flush in CALC cycle 10 of a DIV
    saved = result;
    vc    = valid_cnt;
    c0    = cyc;
    launch(3'd4, 32'd1000, 32'd3, 1'b0);
    while (cyc < c0 + 10) wait_cycles(1);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'h0);
    wait_cycles(40);
    check("flush_no_valid", 32'(valid_cnt), 32'(vc));
    check("flush_result_held", result, saved);

    // Start and flush in the same cycle
    vc    = valid_cnt;
    flush = 1'b1;
    launch(3'd5, 32'd99, 32'd9, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    check("start_flush_busy", {31'b0, busy}, 32'h0);
    wait_cycles(40);
    check("start_flush_no_valid", 32'(valid_cnt), 32'(vc));

    // Back-to-back: the second start is given in the DONE cycle of the first
    c0 = cyc;
    launch(3'd5, 32'd12345, 32'd11, 1'b1);
    while (cyc < c0 + latency(3'd5, 32'd12345, 32'd11)) wait_cycles(1);
    launch(3'd0, 32'h0001_0003, 32'h0000_0007, 1'b1);
    drain();

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = pick();
      b = pick();
      run(3'($urandom_range(0, 7)), a, b);
    end

    // Asynchronous reset during CALC
    run(3'd5, 32'd100, 32'd7);
    launch(3'd0, 32'd3, 32'd5, 1'b0);
    wait_cycles(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",   {31'b0, busy},  32'h0);
    check("async_rst_valid",  {31'b0, valid}, 32'h0);
    check("async_rst_result", result,         32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(2);
    run(3'd6, 32'hFFFF_FF00, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
